// File: rtl/playfield_plotter_if.sv
// Bus between the game datapath (master) and the playfield plotter (slave):
// column push handshake, bitmap clear, render request with sprite position,
// and the one-pixel-per-cycle framebuffer write stream.
interface playfield_plotter_if #(
    parameter int COLS = 120,
    parameter int ROWS = 100,
    parameter int XW   = 8,
    parameter int YW   = 7
);
    localparam int SXW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SYW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic            col_valid;
    logic [ROWS-1:0] col_data;
    logic            col_ready;
    logic            clr;
    logic            start;
    logic [SXW-1:0]  spr_x;
    logic [SYW-1:0]  spr_y;
    logic            busy;
    logic            done;
    logic            plot;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [2:0]      colour;

    modport master (
        output col_valid, col_data, clr, start, spr_x, spr_y,
        input  col_ready, busy, done, plot, x, y, colour
    );

    modport slave (
        input  col_valid, col_data, clr, start, spr_x, spr_y,
        output col_ready, busy, done, plot, x, y, colour
    );
endinterface

// File: rtl/playfield_plotter.sv
// Playfield renderer: column-shift wall bitmap plus a one-pixel-per-cycle
// stream of every field pixel (column-major) followed by the player sprite.
// Optional feature macro: PLAYFIELD_SPRITE_EN (sprite pass present when defined).
module playfield_plotter #(
    parameter int       COLS        = 120,
    parameter int       ROWS        = 100,
    parameter int       X0          = 20,
    parameter int       Y0          = 10,
    parameter int       XW          = 8,
    parameter int       YW          = 7,
    parameter int       SPR_W       = 4,
    parameter int       SPR_H       = 6,
    parameter logic [2:0] WALL_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] SPR_COLOUR  = 3'b100
) (
    input  logic                clk,
    input  logic                resetn,
    playfield_plotter_if.slave  bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [XW-1:0] X0_W = XW'(X0);
    localparam logic [YW-1:0] Y0_W = YW'(Y0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALLS  = 2'd1,
        ST_SPRITE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e          state_q;
    logic [ROWS-1:0] bitmap_q [COLS];
    logic [ROWS-1:0] base_s   [COLS];
    logic [ROWS-1:0] bitmap_d [COLS];
    logic [CW-1:0]   c_q;
    logic [RW-1:0]   r_q;
    logic            plot_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [2:0]      colour_q;
    logic            busy_q;
    logic            done_q;

`ifdef PLAYFIELD_SPRITE_EN
    localparam int IW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int JW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    logic [CW-1:0] sx_q;
    logic [RW-1:0] sy_q;
    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic          spr_vis_s;

    // A sprite pixel is drawn only while it lies inside the field.
    assign spr_vis_s = ((32'(sx_q) + 32'(i_q)) < 32'(COLS)) &&
                       ((32'(sy_q) + 32'(j_q)) < 32'(ROWS));
`else
    logic [31:0] unused_spr_s;
    assign unused_spr_s = 32'(SPR_W) ^ 32'(SPR_H) ^ 32'(SPR_COLOUR) ^
                          32'(bus.spr_x) ^ 32'(bus.spr_y);
`endif

    assign bus.col_ready = (state_q == ST_IDLE);
    assign bus.plot      = plot_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = colour_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Next bitmap: in IDLE a clear happens first, then the optional push shifts left.
    always_comb begin
        for (int k = 0; k < COLS; k++) begin
            base_s[k]   = bitmap_q[k];
            bitmap_d[k] = bitmap_q[k];
        end
        if (state_q == ST_IDLE) begin
            for (int k = 0; k < COLS; k++) begin
                base_s[k] = bus.clr ? {ROWS{1'b0}} : bitmap_q[k];
            end
            if (bus.col_valid) begin
                for (int k = 0; k < COLS - 1; k++) begin
                    bitmap_d[k] = base_s[k+1];
                end
                bitmap_d[COLS-1] = bus.col_data;
            end else begin
                for (int k = 0; k < COLS; k++) begin
                    bitmap_d[k] = base_s[k];
                end
            end
        end else begin
            for (int k = 0; k < COLS; k++) begin
                bitmap_d[k] = bitmap_q[k];
            end
        end
    end

    // Bitmap storage; frozen outside IDLE by construction of bitmap_d.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < COLS; k++) begin
                bitmap_q[k] <= {ROWS{1'b0}};
            end
        end else begin
            for (int k = 0; k < COLS; k++) begin
                bitmap_q[k] <= bitmap_d[k];
            end
        end
    end

    // Render FSM: walks field pixels then sprite pixels, all outputs registered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            c_q      <= {CW{1'b0}};
            r_q      <= {RW{1'b0}};
            plot_q   <= 1'b0;
            x_q      <= {XW{1'b0}};
            y_q      <= {YW{1'b0}};
            colour_q <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PLAYFIELD_SPRITE_EN
            sx_q     <= {CW{1'b0}};
            sy_q     <= {RW{1'b0}};
            i_q      <= {IW{1'b0}};
            j_q      <= {JW{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
`ifdef PLAYFIELD_SPRITE_EN
                        sx_q <= bus.spr_x;
                        sy_q <= bus.spr_y;
`endif
                        c_q     <= {CW{1'b0}};
                        r_q     <= {RW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_WALLS;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_WALLS: begin
                    plot_q   <= 1'b1;
                    x_q      <= X0_W + XW'(c_q);
                    y_q      <= Y0_W + YW'(r_q);
                    colour_q <= bitmap_q[c_q][r_q] ? WALL_COLOUR : BG_COLOUR;
                    if (r_q == RW'(ROWS - 1)) begin
                        r_q <= {RW{1'b0}};
                        if (c_q == CW'(COLS - 1)) begin
                            c_q <= {CW{1'b0}};
`ifdef PLAYFIELD_SPRITE_EN
                            i_q     <= {IW{1'b0}};
                            j_q     <= {JW{1'b0}};
                            state_q <= ST_SPRITE;
`else
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
`endif
                        end else begin
                            c_q <= c_q + CW'(1);
                        end
                    end else begin
                        r_q <= r_q + RW'(1);
                    end
                end
`ifdef PLAYFIELD_SPRITE_EN
                ST_SPRITE: begin
                    plot_q   <= spr_vis_s;
                    x_q      <= X0_W + XW'(sx_q) + XW'(i_q);
                    y_q      <= Y0_W + YW'(sy_q) + YW'(j_q);
                    colour_q <= SPR_COLOUR;
                    if (j_q == JW'(SPR_H - 1)) begin
                        j_q <= {JW{1'b0}};
                        if (i_q == IW'(SPR_W - 1)) begin
                            i_q     <= {IW{1'b0}};
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            i_q <= i_q + IW'(1);
                        end
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
`endif
                ST_DONE: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_playfield_plotter.sv
// Directed table-driven bench for playfield_plotter (COLS=4, ROWS=3, SPR 2x2).
module tb_playfield_plotter;
    localparam int WALL_N = 12;
`ifdef PLAYFIELD_SPRITE_EN
    localparam int RLEN = 17;
`else
    localparam int RLEN = 13;
`endif

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    playfield_plotter_if #(.COLS(4), .ROWS(3), .XW(8), .YW(7)) bus ();

    playfield_plotter #(
        .COLS(4), .ROWS(3), .X0(20), .Y0(10), .XW(8), .YW(7),
        .SPR_W(2), .SPR_H(2),
        .WALL_COLOUR(3'b111), .BG_COLOUR(3'b000), .SPR_COLOUR(3'b100)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        logic        clr;    // clear before the render
        logic        pv;     // push before (or with) start
        logic [2:0]  pd;
        logic        ws;     // apply clr/push in the start cycle
        logic        poke;   // fire start/push/clr mid-render
        int          sx;
        int          sy;
        logic [11:0] frame;  // bit c*3+r set where wall colour expected
        logic [3:0]  mask;   // sprite plot bits, index i*2+j
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_render(input logic s_clr, input logic s_pv, input logic [2:0] s_pd,
                              input int sx, input int sy, input logic poke,
                              output logic [11:0] frame, output logic [3:0] mask,
                              output int done_at, output int ord_err,
                              output int busy_err, output int nplot);
        int cyc;
        int xi;
        int yi;
        int n;
        frame = 12'h000; mask = 4'b0000; done_at = -1;
        ord_err = 0; busy_err = 0; nplot = 0; n = 0;
        bus.start = 1'b1; bus.spr_x = 2'(sx); bus.spr_y = 2'(sy);
        bus.clr = s_clr; bus.col_valid = s_pv; bus.col_data = s_pd;
        tick();
        bus.start = 1'b0; bus.clr = 1'b0; bus.col_valid = 1'b0;
        cyc = 0;
        if (bus.busy !== 1'b1) busy_err++;
        while (done_at < 0 && cyc < 40) begin
            if (poke && cyc == 5) begin
                bus.start = 1'b1; bus.col_valid = 1'b1; bus.col_data = 3'b111; bus.clr = 1'b1;
            end
            tick();
            cyc++;
            bus.start = 1'b0; bus.col_valid = 1'b0; bus.clr = 1'b0;
            xi = int'(bus.x) - 20;
            yi = int'(bus.y) - 10;
            if (bus.done === 1'b1) done_at = cyc;
            if (cyc <= WALL_N) begin
                if (bus.plot === 1'b1) nplot++;
                if (xi != (cyc - 1) / 3 || yi != (cyc - 1) % 3) ord_err++;
                if (bus.colour == 3'd7) frame[cyc-1] = 1'b1;
                else if (bus.colour != 3'd0) ord_err++;
                if (cyc <= 10 && bus.busy !== 1'b1) busy_err++;
            end
`ifdef PLAYFIELD_SPRITE_EN
            else if (cyc <= WALL_N + 4) begin
                n = cyc - WALL_N - 1;
                mask[n] = bus.plot;
                if (xi != sx + n / 2 || yi != sy + n % 2) ord_err++;
                if (bus.colour != 3'd4) ord_err++;
            end
`endif
            else begin
                if (bus.busy !== 1'b0 || bus.plot !== 1'b0) busy_err++;
            end
        end
    endtask

    logic [11:0] got_frame;
    logic [3:0]  got_mask;
    int          got_done;
    int          got_ord;
    int          got_busy;
    int          got_plot;
    int          stray;

    initial begin
        vt[0] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0, 0, 12'h000, 4'b1111};
        vt[1] = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 0, 0, 12'hA00, 4'b1111};
        vt[2] = '{1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 3, 2, 12'h200, 4'b0001};
        vt[3] = '{1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 2, 1, 12'h440, 4'b1111};
        vt[4] = '{1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 3, 0, 12'hE88, 4'b0011};
        vt[5] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1, 2, 12'hE88, 4'b0101};
        vt[6] = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 0, 0, 12'h000, 4'b1111};

        resetn = 1'b0;
        bus.col_valid = 1'b0; bus.col_data = 3'b000; bus.clr = 1'b0;
        bus.start = 1'b0; bus.spr_x = 2'd0; bus.spr_y = 2'd0;
        repeat (3) tick();
        check("rst plot", int'(bus.plot), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst done", int'(bus.done), 0);
        check("rst col_ready", int'(bus.col_ready), 1);
        check("rst xyc", int'(bus.x) + int'(bus.y) + int'(bus.colour), 0);
        resetn = 1'b1;
        tick();
        check("post-rst plot", int'(bus.plot), 0);
        check("post-rst col_ready", int'(bus.col_ready), 1);

        for (int k = 0; k < 7; k++) begin
            if (!vt[k].ws) begin
                bus.clr = vt[k].clr; bus.col_valid = vt[k].pv; bus.col_data = vt[k].pd;
                tick();
                bus.clr = 1'b0; bus.col_valid = 1'b0;
                run_render(1'b0, 1'b0, 3'b000, vt[k].sx, vt[k].sy, vt[k].poke,
                           got_frame, got_mask, got_done, got_ord, got_busy, got_plot);
            end else begin
                run_render(vt[k].clr, vt[k].pv, vt[k].pd, vt[k].sx, vt[k].sy, vt[k].poke,
                           got_frame, got_mask, got_done, got_ord, got_busy, got_plot);
            end
            check($sformatf("v%0d frame", k), int'(got_frame), int'(vt[k].frame));
            check($sformatf("v%0d order", k), got_ord, 0);
            check($sformatf("v%0d wall plots", k), got_plot, WALL_N);
            check($sformatf("v%0d done latency", k), got_done, RLEN);
            check($sformatf("v%0d busy", k), got_busy, 0);
`ifdef PLAYFIELD_SPRITE_EN
            check($sformatf("v%0d sprite mask", k), int'(got_mask), int'(vt[k].mask));
`endif
            tick();
            check($sformatf("v%0d done pulse width", k), int'(bus.done), 0);
            check($sformatf("v%0d col_ready after", k), int'(bus.col_ready), 1);
            stray = 0;
            repeat (4) begin
                tick();
                if (bus.busy !== 1'b0 || bus.plot !== 1'b0 || bus.done !== 1'b0) stray++;
            end
            check($sformatf("v%0d no second render", k), stray, 0);
        end

        // Reset in the middle of the wall pass.
        bus.col_valid = 1'b1; bus.col_data = 3'b111;
        tick();
        bus.col_valid = 1'b0;
        bus.start = 1'b1; bus.spr_x = 2'd0; bus.spr_y = 2'd0;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("mid plot before reset", int'(bus.plot), 1);
        check("mid pixel5 x", int'(bus.x), 21);
        resetn = 1'b0;
        tick();
        check("mid-rst plot", int'(bus.plot), 0);
        check("mid-rst busy", int'(bus.busy), 0);
        check("mid-rst col_ready", int'(bus.col_ready), 1);
        resetn = 1'b1;
        stray = 0;
        repeat (25) begin
            tick();
            if (bus.done !== 1'b0 || bus.plot !== 1'b0) stray++;
        end
        check("mid-rst no done", stray, 0);
        run_render(1'b0, 1'b0, 3'b000, 0, 0, 1'b0,
                   got_frame, got_mask, got_done, got_ord, got_busy, got_plot);
        check("mid-rst bitmap zero", int'(got_frame), 0);
        check("mid-rst render latency", got_done, RLEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/playfield_plotter.md
# playfield_plotter

Parametrised playfield renderer for the jump game. Holds a column-shift wall bitmap (COLS × ROWS), accepts one new wall column per push, and on `start` streams every field pixel, then the player sprite, as one-pixel-per-cycle `plot`/`x`/`y`/`colour` writes into the VGA adapter. Sits between the game datapath, which owns scroll, collision and the sprite position, and the `vga_adapter` framebuffer.

## Interface
Parameters:
- COLS, 120, field width in columns
- ROWS, 100, field height in rows
- X0, 20, screen x of column 0
- Y0, 10, screen y of row 0
- XW, 8, width of `x` output
- YW, 7, width of `y` output
- SPR_W, 4, sprite width
- SPR_H, 6, sprite height
- WALL_COLOUR, 3'b111, colour of set cells
- BG_COLOUR, 3'b000, colour of clear cells
- SPR_COLOUR, 3'b100, sprite colour

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- col_valid  in  1  push request for a new column
- col_data  in  ROWS  new column; bit r is row r
- col_ready  out  1  high in IDLE only
- clr  in  1  clears the whole bitmap; honoured in IDLE only
- start  in  1  render request
- spr_x  in  $clog2(COLS)  sprite column, sampled on start
- spr_y  in  $clog2(ROWS)  sprite row, sampled on start
- busy  out  1  high while a render is in progress
- done  out  1  one-cycle pulse when a render ends
- plot  out  1  pixel write strobe
- x  out  XW  screen x
- y  out  YW  screen y
- colour  out  3  pixel colour

## Operation
- States: IDLE, WALLS, SPRITE, DONE.
- **IDLE**
  - `col_valid` shifts the bitmap: col[i] ← col[i+1] for i < COLS-1, then col[COLS-1] ← `col_data`.
  - `clr` zeroes the bitmap. If `clr` and `col_valid` arrive together, `clr` is applied first, so only col[COLS-1] ends up holding `col_data`.
  - `start` latches `spr_x` and `spr_y`, clears the column counter c and row counter r to 0, and enters WALLS.
  - A push or clear in the same cycle as `start` is applied before rendering, so the render sees the updated bitmap.
- **WALLS**
  - One pixel per cycle, column-major: r is the inner counter (0..ROWS-1), c the outer counter (0..COLS-1).
  - Each pixel: `plot`=1, `x`=X0+c, `y`=Y0+r, `colour`=WALL_COLOUR if col[c][r] is set, else BG_COLOUR.
  - After pixel (COLS-1, ROWS-1) → SPRITE, with sprite counters i=j=0.
- **SPRITE**
  - SPR_W×SPR_H cycles, j inner (0..SPR_H-1), i outer (0..SPR_W-1).
  - Each pixel: `x`=X0+sx+i, `y`=Y0+sy+j, `colour`=SPR_COLOUR.
  - Pixels with sx+i ≥ COLS or sy+j ≥ ROWS are clipped: `plot`=0, but they still take their cycle.
  - After the last pixel → DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `busy`=1 in WALLS and SPRITE. In IDLE and DONE, `plot`=0.
- `start`, `col_valid` and `clr` outside IDLE are ignored and not queued. The bitmap is frozen during a render.
- Arithmetic: `x` and `y` are truncated to XW and YW bits. Choosing X0+COLS+SPR_W ≤ 2^XW (and likewise for y) is the integrator's job; no saturation is applied.

## Timing
- All outputs are registered.
- `start` sampled at edge k → first pixel on the outputs after edge k+1.
- Total render, start edge to `done` pulse: COLS·ROWS + SPR_W·SPR_H + 1 cycles. The length is fixed and independent of clipping and bitmap contents.
- `col_ready` is combinational from the state register and is high in the cycle after `done`.
- Reset values: state IDLE, bitmap all 0, `plot` 0, `x` 0, `y` 0, `colour` 0, `busy` 0, `done` 0, `col_ready` 1.
- Reset mid-render aborts immediately: no `done` pulse, bitmap cleared.

## Configuration
- `PLAYFIELD_SPRITE_EN` defined: SPRITE state present; behaviour as above.
- Not defined:
  - WALLS goes directly to DONE; `spr_x` and `spr_y` are ignored.
  - Render length is COLS·ROWS + 1 cycles.
  - SPR_* parameters have no effect.

## Test plan
Bench parameters: COLS=4, ROWS=3, X0=20, Y0=10, SPR_W=2, SPR_H=2.
- **Reset**: reset then release → `plot`=0, `busy`=0, `col_ready`=1; a render emits only BG_COLOUR for all 12 wall pixels.
- **Push and order**: push 3'b101, then `start` with spr=(0,0) → pixels at (23,10)=7, (23,11)=0, (23,12)=7; first pixel (20,10) appears 1 cycle after the start edge; `done` arrives 17 cycles after the start edge.
- **Shift**: push 3'b001 then 3'b010 → col[2]=001 and col[3]=010; pixel (22,10)=7, pixel (23,11)=7.
- **Clipping**: spr=(3,2) → sprite pixels (23,12) plotted with colour 4; the other three have `plot`=0; `done` timing unchanged at 17 cycles.
- **Simultaneous / ignored requests**: `start` together with a push of 3'b111 → column 3 renders all WALL_COLOUR. A push or `start` during `busy` → bitmap unchanged, no second render.
- **Reset mid-render**: `resetn`=0 at wall pixel 5 → next cycle `plot`=0, `busy`=0, no `done`, bitmap zero.
